// File: rtl/freq_meter_if.sv
// ----------------------------------------------------------------------------
// freq_meter_if: bundles the measured input, the single-shot trigger and the
// measurement result of freq_meter.
//   sig_in    signal being measured (asynchronous to the meter clock)
//   start     single-shot trigger (ignored in continuous mode)
//   freq      edge count of the last completed window
//   valid     one-cycle pulse when freq/overflow update
//   busy      a gate window is open
//   overflow  last completed window saturated the edge counter
// master drives sig_in/start and observes results; slave is the meter.
// ----------------------------------------------------------------------------
interface freq_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             sig_in;
    logic             start;
    logic [CNT_W-1:0] freq;
    logic             valid;
    logic             busy;
    logic             overflow;

    modport master (
        output sig_in,
        output start,
        input  freq,
        input  valid,
        input  busy,
        input  overflow
    );

    modport slave (
        input  sig_in,
        input  start,
        output freq,
        output valid,
        output busy,
        output overflow
    );
endinterface

// File: rtl/freq_meter.sv
// ----------------------------------------------------------------------------
// freq_meter: gated-window frequency counter.
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk50M cycles and publishes the count (Hz when the window is 1 s).
//   clk50M  system clock, all logic on its rising edge
//   rst     synchronous active-high reset
//   bus     freq_meter_if slave: sig_in, start in; freq, valid, busy,
//           overflow out (all outputs registered)
// Parameters:
//   GATE_CYCLES  window length in clk50M cycles (>= 2)
//   CNT_W        width of the edge counter and result
//   CONTINUOUS   1: back-to-back windows; 0: one window per start pulse
// ----------------------------------------------------------------------------
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 32,
    parameter bit          CONTINUOUS  = 1'b1
) (
    input  logic         clk50M,
    input  logic         rst,
    freq_meter_if.slave  bus
);

    // Gate counter only needs to hold GATE_CYCLES-1.
    localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [GATE_W-1:0]  gate_q,  gate_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               sat_q,   sat_d;
    logic [CNT_W-1:0]   freq_q,  freq_d;
    logic               ovf_q,   ovf_d;
    logic               valid_q, valid_d;
    logic               busy_q,  busy_d;

    logic               s1_q, s2_q, s3_q;
    logic               rise_c;
    logic               last_c;
    logic               cnt_max_c;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_c    = s2_q & ~s3_q;
    assign last_c    = (gate_q == GATE_LAST);
    assign cnt_max_c = (cnt_q == {CNT_W{1'b1}});

    // State and datapath registers.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                gate_d = '0;
                cnt_d  = '0;
                sat_d  = 1'b0;
                if (CONTINUOUS || bus.start) begin
                    state_d = MEASURE;
                end
            end

            MEASURE: begin
                // Saturating edge accumulation; an attempted increment at max
                // latches the sticky saturation flag instead of wrapping.
                if (rise_c) begin
                    if (cnt_max_c) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                if (last_c) begin
                    // Publish including this cycle's edge, then restart the
                    // window with no dead cycle so no edge is lost.
                    freq_d  = cnt_d;
                    ovf_d   = sat_d;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    gate_d  = '0;
                    if (!CONTINUOUS) begin
                        state_d = IDLE;
                    end
                end else begin
                    gate_d = gate_q + GATE_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MEASURE);
    end

    assign bus.freq     = freq_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = ovf_q;

endmodule
